// File: rtl/fetch_stage.sv
// fetch_stage: IF stage plus IF/ID pipeline register for the 5-stage RV32I pipeline.
// Holds the PC, fetches over an imem req/ack handshake, buffers one returned
// instruction across load-use stalls and discards stale responses after redirects.
//
// Ports:
//   clk, reset_x                  clock, synchronous active-high reset
//   Fi_stall                      hazard-unit F/D hold
//   Ei_PCSrc, Ei_*Target          E-stage redirect (01 branch, 10 jalr, 11 trap)
//   Di_jal, Di_jalTarget          D-stage jal redirect (ignored while stalled)
//   Fo_iReq, Fo_iAddr             imem request and word address
//   Fi_iAck, Fi_iData             imem response
//   Do_instr/PC/PCplus4/valid     IF/ID register contents to decode
//   Fo_bubbleCnt, Fo_redirectCnt  perf counters (macro FETCH_PERF_EN, else 0)
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset_x,
    input  logic        Fi_stall,
    input  logic [1:0]  Ei_PCSrc,
    input  logic [31:0] Ei_branchTarget,
    input  logic [31:0] Ei_jalrTarget,
    input  logic        Di_jal,
    input  logic [31:0] Di_jalTarget,
    output logic        Fo_iReq,
    output logic [31:0] Fo_iAddr,
    input  logic        Fi_iAck,
    input  logic [31:0] Fi_iData,
    output logic [31:0] Do_instr,
    output logic [31:0] Do_PC,
    output logic [31:0] Do_PCplus4,
    output logic        Do_valid,
    output logic [31:0] Fo_bubbleCnt,
    output logic [31:0] Fo_redirectCnt
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_SKID = 2'd2,
        S_DROP = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] skid_q, skid_d;
    logic [31:0] pend_q, pend_d;
    logic        req_q, req_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] dpc_q, dpc_d;
    logic [31:0] dpc4_q, dpc4_d;
    logic        valid_q, valid_d;

    logic        e_redir_c, d_redir_c, redir_c, bubble_c;
    logic [31:0] target_raw_c, target_c, pc_plus4_c;

    // Redirect selection: E beats D; D jal is only accepted when not stalled.
    always_comb begin
        e_redir_c = (Ei_PCSrc != 2'b00);
        d_redir_c = Di_jal & ~Fi_stall;
        redir_c   = e_redir_c | d_redir_c;
        case (Ei_PCSrc)
            2'b01:   target_raw_c = Ei_branchTarget;
            2'b10:   target_raw_c = Ei_jalrTarget;
            2'b11:   target_raw_c = TRAP_VECTOR;
            default: target_raw_c = Di_jalTarget;
        endcase
        target_c   = {target_raw_c[31:2], 2'b00};
        pc_plus4_c = pc_q + 32'd4;
    end

    // Next-state, PC and IF/ID update.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        skid_d   = skid_q;
        pend_d   = pend_q;
        instr_d  = instr_q;
        dpc_d    = dpc_q;
        dpc4_d   = dpc4_q;
        valid_d  = valid_q;
        bubble_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (redir_c) begin
                    pc_d     = target_c;
                    bubble_c = 1'b1;
                end
            end
            S_REQ: begin
                if (Fi_iAck) begin
                    if (redir_c) begin
                        pc_d     = target_c;
                        bubble_c = 1'b1;
                    end else if (!Fi_stall) begin
                        instr_d = Fi_iData;
                        dpc_d   = pc_q;
                        dpc4_d  = pc_plus4_c;
                        valid_d = 1'b1;
                        pc_d    = pc_plus4_c;
                    end else begin
                        skid_d  = Fi_iData;
                        state_d = S_SKID;
                    end
                end else if (redir_c) begin
                    // Keep the stale address on the bus until memory answers it.
                    pend_d   = target_c;
                    state_d  = S_DROP;
                    bubble_c = 1'b1;
                end else if (!Fi_stall) begin
                    bubble_c = 1'b1;
                end
            end
            S_SKID: begin
                if (redir_c) begin
                    pc_d     = target_c;
                    state_d  = S_REQ;
                    bubble_c = 1'b1;
                end else if (!Fi_stall) begin
                    instr_d = skid_q;
                    dpc_d   = pc_q;
                    dpc4_d  = pc_plus4_c;
                    valid_d = 1'b1;
                    pc_d    = pc_plus4_c;
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (redir_c) begin
                    pend_d   = target_c;
                    bubble_c = 1'b1;
                end else if (!Fi_stall) begin
                    bubble_c = 1'b1;
                end
                if (Fi_iAck) begin
                    pc_d    = redir_c ? target_c : pend_q;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (bubble_c) begin
            instr_d = NOP;
            valid_d = 1'b0;
        end

        req_d = (state_d == S_REQ) || (state_d == S_DROP);
    end

    // State and pipeline registers.
    always_ff @(posedge clk) begin
        if (reset_x) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            skid_q  <= NOP;
            pend_q  <= RESET_PC;
            req_q   <= 1'b0;
            instr_q <= NOP;
            dpc_q   <= 32'd0;
            dpc4_q  <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            skid_q  <= skid_d;
            pend_q  <= pend_d;
            req_q   <= req_d;
            instr_q <= instr_d;
            dpc_q   <= dpc_d;
            dpc4_q  <= dpc4_d;
            valid_q <= valid_d;
        end
    end

    assign Fo_iReq    = req_q;
    assign Fo_iAddr   = pc_q;
    assign Do_instr   = instr_q;
    assign Do_PC      = dpc_q;
    assign Do_PCplus4 = dpc4_q;
    assign Do_valid   = valid_q;

`ifdef FETCH_PERF_EN
    logic [31:0] bubble_cnt_q, redirect_cnt_q;

    // Bubble and redirect event counters, free-running and wrapping.
    always_ff @(posedge clk) begin
        if (reset_x) begin
            bubble_cnt_q   <= 32'd0;
            redirect_cnt_q <= 32'd0;
        end else begin
            if (bubble_c) bubble_cnt_q <= bubble_cnt_q + 32'd1;
            if (redir_c)  redirect_cnt_q <= redirect_cnt_q + 32'd1;
        end
    end

    assign Fo_bubbleCnt   = bubble_cnt_q;
    assign Fo_redirectCnt = redirect_cnt_q;
`else
    assign Fo_bubbleCnt   = 32'd0;
    assign Fo_redirectCnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed vector table, hand-written corner
// sequences and randomized traffic, all checked against a queue-based model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_x;
    logic        Fi_stall;
    logic [1:0]  Ei_PCSrc;
    logic [31:0] Ei_branchTarget, Ei_jalrTarget, Di_jalTarget;
    logic        Di_jal;
    logic        Fo_iReq;
    logic [31:0] Fo_iAddr;
    logic        Fi_iAck;
    logic [31:0] Fi_iData;
    logic [31:0] Do_instr, Do_PC, Do_PCplus4;
    logic        Do_valid;
    logic [31:0] Fo_bubbleCnt, Fo_redirectCnt;
    logic        ack_en;

    int n_pass  = 0;
    int n_total = 0;

    fetch_stage #(.RESET_PC(RESET_PC), .TRAP_VECTOR(TRAP_VEC)) dut (
        .clk            (clk),
        .reset_x        (reset_x),
        .Fi_stall       (Fi_stall),
        .Ei_PCSrc       (Ei_PCSrc),
        .Ei_branchTarget(Ei_branchTarget),
        .Ei_jalrTarget  (Ei_jalrTarget),
        .Di_jal         (Di_jal),
        .Di_jalTarget   (Di_jalTarget),
        .Fo_iReq        (Fo_iReq),
        .Fo_iAddr       (Fo_iAddr),
        .Fi_iAck        (Fi_iAck),
        .Fi_iData       (Fi_iData),
        .Do_instr       (Do_instr),
        .Do_PC          (Do_PC),
        .Do_PCplus4     (Do_PCplus4),
        .Do_valid       (Do_valid),
        .Fo_bubbleCnt   (Fo_bubbleCnt),
        .Fo_redirectCnt (Fo_redirectCnt)
    );

    always #5 clk = ~clk;

    // Memory answers only while a request is up.
    assign Fi_iAck = ack_en & Fo_iReq;

    // ---------------- reference model ----------------
    bit          m_started;
    logic [31:0] m_pc, m_pend;
    logic [31:0] m_buf[$];
    bit          m_discard;
    logic [31:0] m_instr, m_dpc, m_dpc4;
    logic        m_valid;
    logic [31:0] m_bcnt, m_rcnt;

    function automatic bit m_req();
        return m_started && (m_buf.size() == 0);
    endfunction

    function automatic void m_deliver(logic [31:0] d);
        m_instr = d;
        m_dpc   = m_pc;
        m_dpc4  = m_pc + 32'd4;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
    endfunction

    function automatic void model_step();
        bit          er, dr, rd, ack, bub;
        logic [31:0] t;
        if (reset_x) begin
            m_started = 0; m_pc = RESET_PC; m_pend = RESET_PC; m_buf.delete();
            m_discard = 0; m_instr = NOP; m_dpc = 0; m_dpc4 = 0; m_valid = 0;
            m_bcnt = 0; m_rcnt = 0;
            return;
        end
        er  = (Ei_PCSrc != 2'b00);
        dr  = Di_jal && !Fi_stall;
        rd  = er || dr;
        t   = (Ei_PCSrc == 2'b01) ? Ei_branchTarget :
              (Ei_PCSrc == 2'b10) ? Ei_jalrTarget :
              (Ei_PCSrc == 2'b11) ? TRAP_VEC : Di_jalTarget;
        t   = t & ~32'h3;
        ack = ack_en && m_req();
        bub = 0;
        if (rd) m_rcnt = m_rcnt + 32'd1;
        if (!m_started) begin
            m_started = 1;
            if (rd) begin m_pc = t; bub = 1; end
        end else if (m_buf.size() > 0) begin
            if (rd) begin m_buf.delete(); m_pc = t; bub = 1; end
            else if (!Fi_stall) m_deliver(m_buf.pop_front());
        end else if (m_discard) begin
            if (rd) begin m_pend = t; bub = 1; end
            else if (!Fi_stall) bub = 1;
            if (ack) begin m_pc = m_pend; m_discard = 0; end
        end else if (ack) begin
            if (rd) begin m_pc = t; bub = 1; end
            else if (!Fi_stall) m_deliver(Fi_iData);
            else m_buf.push_back(Fi_iData);
        end else begin
            if (rd) begin m_discard = 1; m_pend = t; bub = 1; end
            else if (!Fi_stall) bub = 1;
        end
        if (bub) begin
            m_instr = NOP;
            m_valid = 1'b0;
            m_bcnt  = m_bcnt + 32'd1;
        end
    endfunction

    task automatic check_model(string tag);
        logic [31:0] eb, er;
`ifdef FETCH_PERF_EN
        eb = m_bcnt; er = m_rcnt;
`else
        eb = 32'd0; er = 32'd0;
`endif
        n_total++;
        if (Fo_iReq === m_req() && Fo_iAddr === m_pc && Do_instr === m_instr &&
            Do_PC === m_dpc && Do_PCplus4 === m_dpc4 && Do_valid === m_valid)
            n_pass++;
        else
            $display("FAIL model %s: got req=%0b addr=%h instr=%h pc=%h pc4=%h v=%0b, required req=%0b addr=%h instr=%h pc=%h pc4=%h v=%0b",
                     tag, Fo_iReq, Fo_iAddr, Do_instr, Do_PC, Do_PCplus4, Do_valid,
                     m_req(), m_pc, m_instr, m_dpc, m_dpc4, m_valid);
        n_total++;
        if (Fo_bubbleCnt === eb && Fo_redirectCnt === er)
            n_pass++;
        else
            $display("FAIL perf %s: got bubble=%0d redirect=%0d, required bubble=%0d redirect=%0d",
                     tag, Fo_bubbleCnt, Fo_redirectCnt, eb, er);
    endtask

    // One clock: inputs already driven at negedge, check at the next negedge.
    task automatic step(string tag);
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic expect_io(string tag, logic ereq, logic [31:0] eaddr, logic ev, logic [31:0] epc);
        n_total++;
        if (Fo_iReq === ereq && Fo_iAddr === eaddr && Do_valid === ev && Do_PC === epc)
            n_pass++;
        else
            $display("FAIL %s: got req=%0b addr=%h valid=%0b pc=%h, required req=%0b addr=%h valid=%0b pc=%h",
                     tag, Fo_iReq, Fo_iAddr, Do_valid, Do_PC, ereq, eaddr, ev, epc);
    endtask

    task automatic idle_inputs();
        Fi_stall = 0; Ei_PCSrc = 2'b00; Ei_branchTarget = 0; Ei_jalrTarget = 0;
        Di_jal = 0; Di_jalTarget = 0; ack_en = 0; Fi_iData = 0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        stall;
        logic [1:0]  src;
        logic [31:0] btgt;
        logic [31:0] jrtgt;
        logic        jal;
        logic [31:0] jtgt;
        logic        ack;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    localparam int unsigned NVEC = 19;
    vec_t tbl[NVEC];

    function automatic vec_t mk(logic st, logic [1:0] s, logic [31:0] b, logic [31:0] jr,
                                logic j, logic [31:0] jt, logic a,
                                logic rq, logic [31:0] ad, logic v, logic [31:0] pc);
        vec_t x;
        x.stall = st; x.src = s; x.btgt = b; x.jrtgt = jr; x.jal = j; x.jtgt = jt;
        x.ack = a; x.exp_req = rq; x.exp_addr = ad; x.exp_valid = v; x.exp_pc = pc;
        return x;
    endfunction

    initial begin
        //            stall src  btgt          jrtgt   jal jtgt   ack  req addr          v  pc
        tbl[0]  = mk(0, 2'b00, 0,            0,      0, 0,      1,   1, 32'h0,        0, 32'h0);
        tbl[1]  = mk(0, 2'b00, 0,            0,      0, 0,      1,   1, 32'h4,        1, 32'h0);
        tbl[2]  = mk(0, 2'b00, 0,            0,      0, 0,      1,   1, 32'h8,        1, 32'h4);
        tbl[3]  = mk(1, 2'b00, 0,            0,      0, 0,      1,   0, 32'h8,        1, 32'h4);
        tbl[4]  = mk(1, 2'b00, 0,            0,      0, 0,      1,   0, 32'h8,        1, 32'h4);
        tbl[5]  = mk(1, 2'b00, 0,            0,      0, 0,      1,   0, 32'h8,        1, 32'h4);
        tbl[6]  = mk(0, 2'b00, 0,            0,      0, 0,      1,   1, 32'hC,        1, 32'h8);
        tbl[7]  = mk(0, 2'b01, 32'h40,       0,      1, 32'h80, 1,   1, 32'h40,       0, 32'h8);
        tbl[8]  = mk(0, 2'b00, 0,            0,      0, 0,      0,   1, 32'h40,       0, 32'h8);
        tbl[9]  = mk(0, 2'b00, 0,            0,      0, 0,      1,   1, 32'h44,       1, 32'h40);
        tbl[10] = mk(0, 2'b10, 0,            32'h200,0, 0,      0,   1, 32'h44,       0, 32'h40);
        tbl[11] = mk(0, 2'b00, 0,            0,      0, 0,      0,   1, 32'h44,       0, 32'h40);
        tbl[12] = mk(0, 2'b00, 0,            0,      0, 0,      1,   1, 32'h200,      0, 32'h40);
        tbl[13] = mk(0, 2'b11, 0,            0,      0, 0,      1,   1, TRAP_VEC,     0, 32'h40);
        tbl[14] = mk(1, 2'b00, 0,            0,      1, 32'h300,0,   1, TRAP_VEC,     0, 32'h40);
        tbl[15] = mk(0, 2'b00, 0,            0,      1, 32'h300,1,   1, 32'h300,      0, 32'h40);
        tbl[16] = mk(0, 2'b00, 0,            0,      0, 0,      1,   1, 32'h304,      1, 32'h300);
        tbl[17] = mk(0, 2'b01, 32'hFFFF_FFFF,0,      0, 0,      1,   1, 32'hFFFF_FFFC,0, 32'h300);
        tbl[18] = mk(0, 2'b00, 0,            0,      0, 0,      1,   1, 32'h0,        1, 32'hFFFF_FFFC);
    end

    // ---------------- stimulus ----------------
    initial begin
        idle_inputs();
        reset_x = 1;
        @(negedge clk);
        step("reset");
        expect_io("reset_state", 0, RESET_PC, 0, 32'h0);
        n_total++;
        if (Do_instr === NOP && Do_PCplus4 === 32'h0) n_pass++;
        else $display("FAIL reset_instr: got instr=%h pc4=%h, required instr=%h pc4=0", Do_instr, Do_PCplus4, NOP);

        reset_x = 0;
        for (int i = 0; i < int'(NVEC); i++) begin
            Fi_stall        = tbl[i].stall;
            Ei_PCSrc        = tbl[i].src;
            Ei_branchTarget = tbl[i].btgt;
            Ei_jalrTarget   = tbl[i].jrtgt;
            Di_jal          = tbl[i].jal;
            Di_jalTarget    = tbl[i].jtgt;
            ack_en          = tbl[i].ack;
            Fi_iData        = 32'h1000_0000 ^ Fo_iAddr;
            step($sformatf("vec%0d", i));
            expect_io($sformatf("vec%0d", i), tbl[i].exp_req, tbl[i].exp_addr,
                      tbl[i].exp_valid, tbl[i].exp_pc);
        end

        // Redirect while holding a skid entry: skid is dropped.
        idle_inputs();
        ack_en = 1; Fi_stall = 1; Fi_iData = 32'hDEAD_0001;
        step("skid_fill");
        Fi_stall = 0; Ei_PCSrc = 2'b01; Ei_branchTarget = 32'h500;
        step("skid_redirect");
        expect_io("skid_redirect", 1, 32'h500, 0, 32'hFFFF_FFFC);

        // Reset while a request waits for its ack.
        idle_inputs();
        step("wait0");
        step("wait1");
        reset_x = 1;
        step("reset_mid");
        expect_io("reset_mid", 0, RESET_PC, 0, 32'h0);
        reset_x = 0;
        step("after_reset");
        expect_io("after_reset", 1, RESET_PC, 0, 32'h0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            int unsigned r;
            reset_x         = ($urandom_range(0, 299) == 0);
            Fi_stall        = ($urandom_range(0, 3) == 0);
            r               = $urandom_range(0, 19);
            Ei_PCSrc        = (r < 17) ? 2'b00 : 2'(r - 16);
            Ei_branchTarget = $urandom;
            Ei_jalrTarget   = $urandom;
            Di_jal          = ($urandom_range(0, 14) == 0);
            Di_jalTarget    = $urandom;
            ack_en          = ($urandom_range(0, 9) < 6);
            Fi_iData        = $urandom;
            step($sformatf("rand%0d", c));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
